key_event_ctrl: RTL and testbench

- Parametrised successor to the per-switch debouncer used in the clock top: one instance serves N_KEYS push-buttons.
- Adds synchronisation, debounce, and press-event classification to each key: press, short release, long hold, and auto-repeat.
- Sits between the board switch pins and the mode blocks (watch/set/alarm/stopwatch). Long press and auto-repeat let the set modes step values quickly.

---
 rtl/key_event_pkg.sv | 17 +
 rtl/key_event_ch.sv | 143 ++++++++++++++
 rtl/key_event_ctrl.sv | 44 ++++
 tb/tb_key_event_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and default constants for the multi-key event controller.
// Imported by key_event_ch and key_event_ctrl.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_e;

  localparam int DEF_N_KEYS         = 4;
  localparam int DEF_CNT_W          = 12;
  localparam int DEF_DEBOUNCE_TICKS = 20;
  localparam int DEF_LONG_TICKS     = 1000;
  localparam int DEF_REPEAT_TICKS   = 200;

endpackage

// File: rtl/key_event_ch.sv
// One key channel: 2-flop synchroniser, tick-based debounce, and the
// IDLE/HELD/LONG classifier producing press/short/long/repeat pulses.
module key_event_ch
  import key_event_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic en_tick,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS >= (1 << CNT_W)) begin : g_bad_debounce
    $error("key_event_ch: DEBOUNCE_TICKS out of range for CNT_W");
  end
  if (LONG_TICKS < 1 || LONG_TICKS >= (1 << CNT_W)) begin : g_bad_long
    $error("key_event_ch: LONG_TICKS out of range for CNT_W");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS >= (1 << CNT_W)) begin : g_bad_repeat
    $error("key_event_ch: REPEAT_TICKS out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] DBC_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] HC_LAST  = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RC_LAST  = CNT_W'(REPEAT_TICKS - 1);

  logic             sync_q1, sync_q2;
  logic [CNT_W-1:0] dbc_q;
  logic             toggle, rise, fall;

  // The debounce toggle edge is also the FSM's rise/fall event, so a
  // release and a hold threshold can land on the same edge.
  assign toggle = (sync_q2 != key_level) && en_tick && (dbc_q == DBC_LAST);
  assign rise   = toggle && !key_level;
  assign fall   = toggle &&  key_level;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      key_level <= 1'b0;
      dbc_q     <= '0;
    end else begin
      sync_q1 <= key_in;
      sync_q2 <= sync_q1;
      if (sync_q2 == key_level) begin
        dbc_q <= '0;
      end else if (en_tick) begin
        if (toggle) begin
          key_level <= ~key_level;
          dbc_q     <= '0;
        end else begin
          dbc_q <= dbc_q + 1'b1;
        end
      end
    end
  end

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] hc_q, hc_d, rc_q, rc_d;
  logic             press_d, short_d, long_d, repeat_d;

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    rc_d     = rc_q;
    press_d  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD;
          press_d = 1'b1;
          hc_d    = '0;
        end
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (en_tick) begin
          if (hc_q == HC_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
            rc_d    = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
        end else if (en_tick) begin
          if (rc_q == RC_LAST) begin
            repeat_d = repeat_en;
            rc_d     = '0;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hc_q         <= '0;
      rc_q         <= '0;
      press_pulse  <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      hc_q         <= hc_d;
      rc_q         <= rc_d;
      press_pulse  <= press_d;
      short_pulse  <= short_d;
      long_pulse   <= long_d;
      repeat_pulse <= repeat_d;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// N_KEYS independent key channels sharing one timebase strobe; sits
// between the raw switch pins and the clock's mode blocks.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int N_KEYS         = DEF_N_KEYS,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_tick,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] short_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_event_ch #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en_tick      (en_tick),
      .key_in       (key_in[i]),
      .repeat_en    (repeat_en[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .short_pulse  (short_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed scenarios plus randomized traffic for key_event_ctrl, compared
// every cycle against a tick-counting reference model.
module tb_key_event_ctrl;

  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int LNG  = 10;
  localparam int REP  = 3;

  logic          clk;
  logic          rst;
  logic          en_tick;
  logic [NK-1:0] key_in, repeat_en;
  logic [NK-1:0] key_level, press_pulse, short_pulse, long_pulse, repeat_pulse;

  key_event_ctrl #(
    .N_KEYS(NK), .CNT_W(8), .DEBOUNCE_TICKS(DB), .LONG_TICKS(LNG), .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk), .rst(rst), .en_tick(en_tick), .key_in(key_in), .repeat_en(repeat_en),
    .key_level(key_level), .press_pulse(press_pulse), .short_pulse(short_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: raw input delayed two samples; level flips after DB
  // consecutive ticks of disagreement; events derived from ticks since press.
  bit          m_s1[NK], m_s2[NK], m_lvl[NK], m_pressed[NK];
  int          m_run[NK], m_ticks[NK];
  logic [NK-1:0] e_press, e_short, e_long, e_rep;

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      bit rose, fell;
      rose = 1'b0;
      fell = 1'b0;
      e_press[k] = 1'b0; e_short[k] = 1'b0; e_long[k] = 1'b0; e_rep[k] = 1'b0;
      if (rst) begin
        m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_pressed[k] = 0;
        m_run[k] = 0; m_ticks[k] = 0;
      end else begin
        if (m_s2[k] != m_lvl[k]) begin
          if (en_tick) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
              m_lvl[k] = !m_lvl[k];
              m_run[k] = 0;
              rose = m_lvl[k];
              fell = !m_lvl[k];
            end
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = key_in[k];
        if (rose) begin
          m_pressed[k] = 1; m_ticks[k] = 0; e_press[k] = 1'b1;
        end else if (fell) begin
          if (m_ticks[k] < LNG) e_short[k] = 1'b1;
          m_pressed[k] = 0;
        end else if (m_pressed[k] && en_tick) begin
          m_ticks[k]++;
          if (m_ticks[k] == LNG) e_long[k] = 1'b1;
          else if (m_ticks[k] > LNG && (m_ticks[k] - LNG) % REP == 0) e_rep[k] = repeat_en[k];
        end
      end
    end
  endtask

  function automatic logic [NK-1:0] exp_level();
    logic [NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k] = m_lvl[k];
    return v;
  endfunction

  // Per-scenario tallies of what the DUT produced.
  int n_press[NK], n_short[NK], n_long[NK], n_rep[NK], n_lvl[NK];
  int press_cycles, cyc, press_cyc2, long_cyc2;
  logic [NK-1:0] last_press_vec;
  int rep_q[$];
  int tick_div = 0, tick_cnt = 0;

  task automatic clear_tally();
    for (int k = 0; k < NK; k++) begin
      n_press[k] = 0; n_short[k] = 0; n_long[k] = 0; n_rep[k] = 0; n_lvl[k] = 0;
    end
    press_cycles = 0; last_press_vec = '0; press_cyc2 = 0; long_cyc2 = 0;
    rep_q.delete();
  endtask

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      check("key_level", key_level, exp_level());
      check("press_pulse", press_pulse, e_press);
      check("short_pulse", short_pulse, e_short);
      check("long_pulse", long_pulse, e_long);
      check("repeat_pulse", repeat_pulse, e_rep);
      for (int k = 0; k < NK; k++) begin
        n_press[k] += press_pulse[k]; n_short[k] += short_pulse[k];
        n_long[k]  += long_pulse[k];  n_rep[k]   += repeat_pulse[k];
        n_lvl[k]   += key_level[k];
      end
      if (press_pulse != '0) begin press_cycles++; last_press_vec = press_pulse; end
      if (press_pulse[2]) press_cyc2 = cyc;
      if (long_pulse[2]) long_cyc2 = cyc;
      if (repeat_pulse[2]) rep_q.push_back(cyc);
      if (tick_div > 0) begin
        tick_cnt++;
        en_tick = (tick_cnt % tick_div) == 0;
      end
    end
  endtask

  int dur[NK];
  int rep_want[3] = '{13, 16, 19};

  initial begin
    cyc = 0;
    rst = 1'b1; en_tick = 1'b1; key_in = '0; repeat_en = '0;
    clear_tally();
    step(2);
    check("rst_level", key_level, 0);
    check("rst_pulses", press_pulse | short_pulse | long_pulse | repeat_pulse, 0);
    rst = 1'b0;
    step(3);

    // Clean press of key0, 6 ticks, released.
    clear_tally();
    key_in = 4'b0001;
    step(5);
    check("s1_lvl_early", key_level[0], 0);
    step(1);
    check("s1_lvl_rise", key_level[0], 1);
    check("s1_press_now", press_pulse[0], 1);
    key_in = 4'b0000;
    step(14);
    check("s1_press_cnt", n_press[0], 1);
    check("s1_short_cnt", n_short[0], 1);
    check("s1_long_cnt", n_long[0], 0);

    // Key1 bounce then steady.
    clear_tally();
    key_in = 4'b0010; step(2);
    key_in = 4'b0000; step(2);
    key_in = 4'b0010; step(2);
    key_in = 4'b0000; step(2);
    check("s2_bounce_lvl", n_lvl[1], 0);
    key_in = 4'b0010;
    step(5);
    check("s2_lvl_early", key_level[1], 0);
    step(1);
    check("s2_lvl_rise", key_level[1], 1);
    key_in = 4'b0000;
    step(12);
    check("s2_press_cnt", n_press[1], 1);

    // Key2 held 20 ticks, repeat enabled then disabled.
    for (int pass = 0; pass < 2; pass++) begin
      clear_tally();
      repeat_en = (pass == 0) ? 4'b0100 : 4'b0000;
      key_in = 4'b0100;
      step(20);
      key_in = 4'b0000;
      step(12);
      check("s3_press_cnt", n_press[2], 1);
      check("s3_long_cnt", n_long[2], 1);
      check("s3_long_at", long_cyc2 - press_cyc2, LNG);
      check("s3_short_cnt", n_short[2], 0);
      check("s3_rep_cnt", n_rep[2], (pass == 0) ? 3 : 0);
      if (pass == 0 && rep_q.size() == 3)
        for (int i = 0; i < 3; i++) check("s3_rep_at", rep_q[i] - press_cyc2, rep_want[i]);
    end
    repeat_en = '0;

    // Keys 0 and 3 together.
    clear_tally();
    key_in = 4'b1001;
    step(8);
    check("s4_press_vec", last_press_vec, 4'b1001);
    check("s4_press_cycles", press_cycles, 1);
    key_in = 4'b0000;
    step(12);

    // Reset at hold tick 7 of key0.
    key_in = 4'b0001;
    step(13);
    rst = 1'b1;
    step(1);
    check("s5_rst_level", key_level, 0);
    check("s5_rst_pulses", press_pulse | short_pulse | long_pulse | repeat_pulse, 0);
    rst = 1'b0;
    clear_tally();
    step(5);
    check("s5_lvl_early", key_level[0], 0);
    step(1);
    check("s5_lvl_rise", key_level[0], 1);
    check("s5_press_now", press_pulse[0], 1);
    check("s5_short_none", n_short[0], 0);
    check("s5_long_none", n_long[0], 0);
    key_in = 4'b0000;
    step(12);

    // Slow timebase: release lands on the threshold tick.
    clear_tally();
    tick_div = 5; tick_cnt = 0; en_tick = 1'b0;
    key_in = 4'b0001;
    step(50);
    key_in = 4'b0000;
    step(60);
    check("s6_press_cnt", n_press[0], 1);
    check("s6_short_cnt", n_short[0], 1);
    check("s6_long_cnt", n_long[0], 0);
    tick_div = 0; en_tick = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < NK; k++) dur[k] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (dur[k] == 0) begin
          key_in[k] = ~key_in[k];
          dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 30);
        end else begin
          dur[k]--;
        end
        if ($urandom_range(0, 19) == 0) repeat_en[k] = ~repeat_en[k];
      end
      en_tick = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0; en_tick = 1'b1; key_in = '0;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
